// File: rtl/id_ctrl_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_ctrl_pkg: opcodes, ALUOp classes and bundle types for the ID stage.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rv32_ctrl_pkg;

  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALUOP_MEM     = 4'b0000,
    ALUOP_OPIMM   = 4'b0001,
    ALUOP_BRANCH  = 4'b0010,
    ALUOP_LUI     = 4'b0011,
    ALUOP_OP      = 4'b0100,
    ALUOP_AUIPC   = 4'b0101,
    ALUOP_JUMP    = 4'b0110,
    ALUOP_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
    logic jump;
  } ctrl_t;

  // One ID/EX pipeline entry; an all-zero entry is a bubble.
  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic [3:0] funct;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    ctrl_t      ctrl;
    logic       illegal;
  } idex_t;

  localparam idex_t C_IDEX_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ctrl_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ctrl_stage_if: IF/ID-side inputs and ID/EX control outputs.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface id_ctrl_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic            stall_in;
  logic            flush;
  logic            hazard_stall;
  logic            ex_valid;
  logic [3:0]      ex_ALUOp;
  logic [3:0]      ex_funct;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic            ex_RegWrite;
  logic            ex_MemRead;
  logic            ex_MemWrite;
  logic            ex_MemtoReg;
  logic            ex_ALUSrc;
  logic            ex_Branch;
  logic            ex_Jump;
  logic            ex_illegal;

  modport master (
    output id_valid, id_instr, stall_in, flush,
    input  hazard_stall, ex_valid, ex_ALUOp, ex_funct, ex_rs1, ex_rs2, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc,
           ex_Branch, ex_Jump, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, stall_in, flush,
    output hazard_stall, ex_valid, ex_ALUOp, ex_funct, ex_rs1, ex_rs2, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc,
           ex_Branch, ex_Jump, ex_illegal
  );
endinterface
`default_nettype wire

// File: rtl/id_ctrl_stage_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_ctrl_decode: combinational opcode/funct decode to ALU class + enables.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rv_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_instr30,
  output alu_op_e    o_alu_op,
  output logic [3:0] o_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_uses_rs2
);

  always_comb begin
    o_alu_op   = ALUOP_MEM;
    o_funct    = 4'b0000;
    o_ctrl     = '0;
    o_illegal  = 1'b0;
    o_uses_rs2 = 1'b0;
    case (i_opcode)
      C_OPC_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      C_OPC_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_uses_rs2       = 1'b1;
      end
      C_OPC_OPIMM: begin
        o_alu_op = ALUOP_OPIMM;
        // instr[30] is an immediate bit except for the shift-right pair
        o_funct  = {(i_funct3 == 3'b101) & i_instr30, i_funct3};
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      C_OPC_OP: begin
        o_alu_op         = ALUOP_OP;
        o_funct          = {i_instr30, i_funct3};
        o_ctrl.reg_write = 1'b1;
        o_uses_rs2       = 1'b1;
      end
      C_OPC_BRANCH: begin
        o_alu_op      = ALUOP_BRANCH;
        o_funct       = {1'b0, i_funct3};
        o_ctrl.branch = 1'b1;
        o_uses_rs2    = 1'b1;
      end
      C_OPC_LUI: begin
        o_alu_op         = ALUOP_LUI;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      C_OPC_AUIPC: begin
        o_alu_op         = ALUOP_AUIPC;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      C_OPC_JAL: begin
        o_alu_op         = ALUOP_JUMP;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
      end
      C_OPC_JALR: begin
        o_alu_op         = ALUOP_JUMP;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      default: begin
        o_alu_op  = ALUOP_ILLEGAL;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ctrl_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ctrl_stage: ID decode, load-use hazard detect and ID/EX control reg.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ctrl_stage
  import rv32_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  id_ctrl_stage_if.slave bus
);

  logic [XLEN-1:0] w_instr;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  alu_op_e         w_alu_op;
  logic [3:0]      w_funct;
  ctrl_t           w_ctrl;
  logic            w_illegal;
  logic            w_uses_rs2;
  logic            w_hazard;
  logic            w_unused_bits;
  idex_t           w_idex_dec;
  idex_t           r_idex;

  assign w_instr       = bus.id_instr;
  assign w_rs1         = w_instr[19:15];
  assign w_rs2         = w_instr[24:20];
  assign w_rd          = w_instr[11:7];
  assign w_unused_bits = ^{w_instr[XLEN-1], w_instr[29:25]};

  rv_ctrl_decode u_decode (
    .i_opcode   (w_instr[6:0]),
    .i_funct3   (w_instr[14:12]),
    .i_instr30  (w_instr[30]),
    .o_alu_op   (w_alu_op),
    .o_funct    (w_funct),
    .o_ctrl     (w_ctrl),
    .o_illegal  (w_illegal),
    .o_uses_rs2 (w_uses_rs2)
  );

  // Compared against the live ID/EX entry; deliberately not gated by stall_in.
  assign w_hazard = bus.id_valid & r_idex.valid & r_idex.ctrl.mem_read &
                    (r_idex.rd != 5'd0) &
                    ((r_idex.rd == w_rs1) | ((r_idex.rd == w_rs2) & w_uses_rs2));

  always_comb begin
    w_idex_dec         = C_IDEX_BUBBLE;
    w_idex_dec.valid   = 1'b1;
    w_idex_dec.alu_op  = w_alu_op;
    w_idex_dec.funct   = w_funct;
    w_idex_dec.rs1     = w_rs1;
    w_idex_dec.rs2     = w_rs2;
    w_idex_dec.rd      = w_rd;
    w_idex_dec.ctrl    = w_ctrl;
    w_idex_dec.illegal = w_illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex <= C_IDEX_BUBBLE;
    end else if (!bus.stall_in) begin
      if (bus.flush || w_hazard || !bus.id_valid) begin
        r_idex <= C_IDEX_BUBBLE;
      end else begin
        r_idex <= w_idex_dec;
      end
    end
  end

  assign bus.hazard_stall = w_hazard;
  assign bus.ex_valid     = r_idex.valid;
  assign bus.ex_ALUOp     = r_idex.alu_op;
  assign bus.ex_funct     = r_idex.funct;
  assign bus.ex_rs1       = r_idex.rs1;
  assign bus.ex_rs2       = r_idex.rs2;
  assign bus.ex_rd        = r_idex.rd;
  assign bus.ex_RegWrite  = r_idex.ctrl.reg_write;
  assign bus.ex_MemRead   = r_idex.ctrl.mem_read;
  assign bus.ex_MemWrite  = r_idex.ctrl.mem_write;
  assign bus.ex_MemtoReg  = r_idex.ctrl.mem_to_reg;
  assign bus.ex_ALUSrc    = r_idex.ctrl.alu_src;
  assign bus.ex_Branch    = r_idex.ctrl.branch;
  assign bus.ex_Jump      = r_idex.ctrl.jump;
  assign bus.ex_illegal   = r_idex.illegal;

endmodule
`default_nettype wire
